// File: rtl/mc_control_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Includes the state encoding, opcode/funct/ALU code constants and the
// Moore decode of control outputs per state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    // Control outputs owned by each state; anything not set stays 0.
    function automatic ctrl_t ctrl_decode(state_t s, logic [3:0] rtype_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 2'd1;
                c.alu_control = ALU_ADD; c.pc_write = 1'b1;
            end
            S_DECODE:    begin c.alu_src_b = 2'd3; c.alu_control = ALU_ADD; end
            S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_control = ALU_ADD; end
            S_MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_control = rtype_alu; end
            S_ALU_WB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_control = ALU_SUB;
                c.pc_source = 2'd1; c.pc_write_cond = 1'b1;
            end
            S_JUMP:      begin c.pc_source = 2'd2; c.pc_write = 1'b1; end
            S_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_control = ALU_ADD; end
            S_ADDI_WB:   c.reg_write = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// IR/datapath bundle between the control unit (master) and the datapath (slave).
interface mc_control_fsm_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic [3:0] AluControl;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       RegWrite;
    logic [1:0] PCSource;
    logic       PcEn;

    modport master (
        input  Opcode, Funct, Zero,
        output AluControl, AluSrcA, AluSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemToReg, RegWrite, PCSource, PcEn
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  AluControl, AluSrcA, AluSrcB, IorD, MemRead, MemWrite, IRWrite,
               RegDst, MemToReg, RegWrite, PCSource, PcEn
    );
endinterface

// File: rtl/mc_control_fsm_alu_control_decode.sv
// R-type funct to ALU operation code; unknown functs fall back to ADD with valid=0.
module alu_control_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       valid
);

    // Pure table lookup on the funct field.
    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM.
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes/functs park the FSM in
// TRAP with Illegal set until reset; without it they retire as NOP / ADD.
// Control outputs are registered from the decode of the next state, so they
// always match State; only PcEn mixes in the live Zero flag.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
)(
    input  logic                   Clock,
    input  logic                   Reset_n,
    mc_control_fsm_if.master       bus,
    output logic                   Illegal,
    output logic [3:0]             State,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t                 state_q, next_state;
    ctrl_t                  ctrl_q;
    logic [5:0]             funct_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   illegal_q;
    logic                   retire;
    logic [5:0]             dec_funct;
    logic [3:0]             dec_alu;
    logic                   funct_valid;

    // The funct is live on the bus in DECODE, when EXEC_R's code is registered.
    assign dec_funct = (state_q == S_DECODE) ? bus.Funct : funct_q;

    alu_control_decode u_alu_dec (
        .funct       (dec_funct),
        .alu_control (dec_alu),
        .valid       (funct_valid)
    );

    // Next-state selection and retire detection.
    always_comb begin
        next_state = S_FETCH;
        retire     = 1'b0;
        case (state_q)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = (funct_valid || !TRAP_EN) ? S_EXEC_R : S_TRAP;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    default: begin
                        next_state = TRAP_EN ? S_TRAP : S_FETCH;
                        retire     = !TRAP_EN;
                    end
                endcase
            end
            S_MEM_ADDR:  next_state = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  next_state = S_MEM_WB;
            S_EXEC_R:    next_state = S_ALU_WB;
            S_ADDI_EXEC: next_state = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:      next_state = TRAP_EN ? S_TRAP : S_FETCH;
            default:     next_state = S_FETCH;
        endcase
    end

    // State, registered controls, latched funct, retire counter, sticky illegal.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_decode(S_FETCH, ALU_ADD);
            funct_q   <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= next_state;
            ctrl_q  <= ctrl_decode(next_state, dec_alu);
            if (state_q == S_DECODE) funct_q <= bus.Funct;
            if (retire) count_q <= count_q + COUNT_WIDTH'(1);
            if (TRAP_EN && next_state == S_TRAP) illegal_q <= 1'b1;
        end
    end

    assign bus.AluControl = ctrl_q.alu_control;
    assign bus.AluSrcA    = ctrl_q.alu_src_a;
    assign bus.AluSrcB    = ctrl_q.alu_src_b;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.MemRead    = ctrl_q.mem_read;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.IRWrite    = ctrl_q.ir_write;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.MemToReg   = ctrl_q.mem_to_reg;
    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.PCSource   = ctrl_q.pc_source;
    assign bus.PcEn       = ctrl_q.pc_write | (ctrl_q.pc_write_cond & bus.Zero);

    assign Illegal    = TRAP_EN ? illegal_q : 1'b0;
    assign State      = state_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table for the legal
// instruction mix, then hand-written reset, illegal-opcode and counter-wrap
// sequences. Works in both CTRL_ILLEGAL_TRAP_EN builds.
module tb_mc_control_fsm;

    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Illegal;
    logic [3:0]    State;
    logic [CW-1:0] InstrCount;

    mc_control_fsm_if bus();

    mc_control_fsm #(.COUNT_WIDTH(CW)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .bus        (bus),
        .Illegal    (Illegal),
        .State      (State),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    // flag order: IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite
    localparam logic [6:0] FL_FETCH = 7'b0101000;
    localparam logic [6:0] FL_NONE  = 7'b0000000;
    localparam logic [6:0] FL_MRD   = 7'b1100000;
    localparam logic [6:0] FL_MWB   = 7'b0000011;
    localparam logic [6:0] FL_MWR   = 7'b1010000;
    localparam logic [6:0] FL_AWB   = 7'b0000101;
    localparam logic [6:0] FL_IWB   = 7'b0000001;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] st;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic [6:0] fl;
        logic [1:0] ps;
        logic       pcen;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input logic [3:0] st, input logic [3:0] alu, input logic sa,
                               input logic [1:0] sb, input logic [6:0] fl, input logic [1:0] ps,
                               input logic pcen, input logic [3:0] cnt);
        vec_t r;
        r.op = op; r.fn = fn; r.z = z; r.st = st; r.alu = alu; r.sa = sa; r.sb = sb;
        r.fl = fl; r.ps = ps; r.pcen = pcen; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset_n    = 1'b0;
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h00;
        bus.Zero   = 1'b0;

        //              op     fn     z   st  alu sa sb fl        ps pcen cnt
        // lw
        tbl.push_back(v(6'h23, 6'h00, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 0));
        tbl.push_back(v(6'h23, 6'h00, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 0));
        tbl.push_back(v(6'h23, 6'h00, 0,  2,  2,  1, 2, FL_NONE,  0, 0, 0));
        tbl.push_back(v(6'h23, 6'h00, 0,  3,  0,  0, 0, FL_MRD,   0, 0, 0));
        tbl.push_back(v(6'h23, 6'h00, 0,  4,  0,  0, 0, FL_MWB,   0, 0, 0));
        // sw
        tbl.push_back(v(6'h2B, 6'h00, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 1));
        tbl.push_back(v(6'h2B, 6'h00, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 1));
        tbl.push_back(v(6'h2B, 6'h00, 0,  2,  2,  1, 2, FL_NONE,  0, 0, 1));
        tbl.push_back(v(6'h2B, 6'h00, 0,  5,  0,  0, 0, FL_MWR,   0, 0, 1));
        // sub
        tbl.push_back(v(6'h00, 6'h22, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 2));
        tbl.push_back(v(6'h00, 6'h22, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 2));
        tbl.push_back(v(6'h00, 6'h22, 0,  6,  6,  1, 0, FL_NONE,  0, 0, 2));
        tbl.push_back(v(6'h00, 6'h22, 0,  7,  0,  0, 0, FL_AWB,   0, 0, 2));
        // nor
        tbl.push_back(v(6'h00, 6'h27, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 3));
        tbl.push_back(v(6'h00, 6'h27, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 3));
        tbl.push_back(v(6'h00, 6'h27, 0,  6,  12, 1, 0, FL_NONE,  0, 0, 3));
        tbl.push_back(v(6'h00, 6'h27, 0,  7,  0,  0, 0, FL_AWB,   0, 0, 3));
        // beq taken
        tbl.push_back(v(6'h04, 6'h00, 1,  0,  2,  0, 1, FL_FETCH, 0, 1, 4));
        tbl.push_back(v(6'h04, 6'h00, 1,  1,  2,  0, 3, FL_NONE,  0, 0, 4));
        tbl.push_back(v(6'h04, 6'h00, 1,  8,  6,  1, 0, FL_NONE,  1, 1, 4));
        // beq not taken
        tbl.push_back(v(6'h04, 6'h00, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 5));
        tbl.push_back(v(6'h04, 6'h00, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 5));
        tbl.push_back(v(6'h04, 6'h00, 0,  8,  6,  1, 0, FL_NONE,  1, 0, 5));
        // addi
        tbl.push_back(v(6'h08, 6'h00, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 6));
        tbl.push_back(v(6'h08, 6'h00, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 6));
        tbl.push_back(v(6'h08, 6'h00, 0,  10, 2,  1, 2, FL_NONE,  0, 0, 6));
        tbl.push_back(v(6'h08, 6'h00, 0,  11, 0,  0, 0, FL_IWB,   0, 0, 6));
        // j
        tbl.push_back(v(6'h02, 6'h00, 0,  0,  2,  0, 1, FL_FETCH, 0, 1, 7));
        tbl.push_back(v(6'h02, 6'h00, 0,  1,  2,  0, 3, FL_NONE,  0, 0, 7));
        tbl.push_back(v(6'h02, 6'h00, 0,  9,  0,  0, 0, FL_NONE,  2, 1, 7));

        // Reset state
        step(2); #1;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_count", 32'(InstrCount), 32'd0);
        chk("reset_fetch_ctrl", 32'({bus.MemRead, bus.IRWrite, bus.PcEn, bus.AluSrcB, bus.AluControl}),
            32'({1'b1, 1'b1, 1'b1, 2'd1, 4'd2}));
        chk("reset_illegal", 32'(Illegal), 32'd0);
        Reset_n = 1'b1;

        // Vector table, one row per cycle
        foreach (tbl[i]) begin
            bus.Opcode = tbl[i].op;
            bus.Funct  = tbl[i].fn;
            bus.Zero   = tbl[i].z;
            #1;
            chk($sformatf("row%0d", i),
                32'({State, bus.AluControl, bus.AluSrcA, bus.AluSrcB, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemToReg, bus.RegWrite,
                     bus.PCSource, bus.PcEn, InstrCount, Illegal}),
                32'({tbl[i].st, tbl[i].alu, tbl[i].sa, tbl[i].sb, tbl[i].fl,
                     tbl[i].ps, tbl[i].pcen, tbl[i].cnt, 1'b0}));
            step(1);
        end

        // Async reset in the middle of a lw
        bus.Opcode = 6'h23;
        bus.Funct  = 6'h00;
        bus.Zero   = 1'b0;
        #1;
        chk("count_after_table", 32'(InstrCount), 32'd8);
        step(3); #1;
        chk("lw_in_mem_read", 32'(State), 32'd3);
        Reset_n = 1'b0;
        #1;
        chk("midlw_reset_state", 32'(State), 32'd0);
        chk("midlw_reset_count", 32'(InstrCount), 32'd0);
        chk("midlw_reset_ctrl", 32'({bus.MemRead, bus.IRWrite, bus.IorD}), 32'b110);
        step(1);
        bus.Opcode = 6'h3F;
        Reset_n = 1'b1;
        #1;
        chk("release_state", 32'(State), 32'd0);
        chk("release_ctrl", 32'({bus.MemRead, bus.IRWrite}), 32'b11);
        step(1); #1;
        chk("illop_decode", 32'(State), 32'd1);
        step(1); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("trap_hold%0d", c),
                32'({State, Illegal, bus.PcEn, bus.MemRead, bus.MemWrite, bus.RegWrite, InstrCount}),
                32'({4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}));
            step(1); #1;
        end
`else
        chk("illop_nop_state", 32'(State), 32'd0);
        chk("illop_nop_count", 32'(InstrCount), 32'd1);
        chk("illop_no_illegal", 32'(Illegal), 32'd0);
`endif

        // Counter wrap: 15 jumps reach all-ones, the 16th wraps to zero
        Reset_n = 1'b0;
        step(1);
        bus.Opcode = 6'h02;
        Reset_n = 1'b1;
        step(45); #1;
        chk("wrap_preload_state", 32'(State), 32'd0);
        chk("wrap_preload_count", 32'(InstrCount), 32'd15);
        step(3); #1;
        chk("wrap_state", 32'(State), 32'd0);
        chk("wrap_count", 32'(InstrCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
